// File: rtl/cluster_clock_divider.sv
// -----------------------------------------------------------------------------
// cluster_clock_divider
//
// Multi-channel, run-time programmable, glitch-free clock divider. Every
// channel owns its own counter and output flop, so channels never share
// a phase reference. Each divided clock has a 50% duty cycle with a period
// of 2*(div+1) source cycles.
//
// A new divide value is written through a req/gnt handshake. It is parked
// in a per-channel holding register and only moves into the active divide
// register at a safe point. A safe point is either the falling toggle of the
// channel's output (the period boundary) or any cycle in which the channel
// is stopped (output low, enable low). As a result no short or runt phase
// can ever appear on an output.
//
// Ports
//   clk_i      source clock
//   rst_i      asynchronous reset, active high
//   en_i       per-channel run enable
//   cfg_req_i  configuration write request
//   cfg_ch_i   target channel of the write
//   cfg_div_i  new divide value
//   cfg_gnt_o  write accepted this cycle (combinational)
//   pend_o     per-channel "value captured, not yet applied"
//   clk_o      divided clocks, each driven straight from a flop
// -----------------------------------------------------------------------------
module cluster_clock_divider #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 0,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_req_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic              cfg_gnt_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] clk_o
);

  // One-hot decode of the addressed channel. An out-of-range index decodes
  // to all zeros, so such a write is granted but touches no channel.
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_en;

  // Stall only when the addressed channel still holds an unapplied value.
  assign cfg_gnt_o = cfg_req_i & ~|(ch_hit & pend_o);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_reg;
      logic [DIV_W-1:0] cnt_next;
      logic [DIV_W-1:0] div_reg;
      logic [DIV_W-1:0] div_next;
      logic [DIV_W-1:0] new_reg;
      logic [DIV_W-1:0] new_next;
      logic             clk_reg;
      logic             clk_next;
      logic             pend_reg;
      logic             pend_next;
      logic             stopped;
      logic             terminal;
      logic             boundary;
      logic             apply;

      assign ch_hit[gi] = (cfg_ch_i == CH_W'(gi));
      assign wr_en[gi]  = cfg_req_i & ch_hit[gi] & ~pend_reg;

      // A channel only stops while its output is low; a high phase that
      // sees enable drop keeps counting until it falls naturally.
      assign stopped  = ~clk_reg & ~en_i[gi];
      assign terminal = (cnt_reg == div_reg);
      // Falling toggle of the output: the only running cycle in which the
      // divide value may change without distorting a phase.
      assign boundary = clk_reg & terminal;
      assign apply    = pend_reg & (stopped | boundary);

      always_comb begin
        cnt_next  = cnt_reg;
        clk_next  = clk_reg;
        div_next  = div_reg;
        new_next  = new_reg;
        pend_next = pend_reg;

        if (stopped) begin
          cnt_next = '0;
        end else if (terminal) begin
          cnt_next = '0;
          clk_next = ~clk_reg;
        end else begin
          cnt_next = cnt_reg + DIV_W'(1);
        end

        if (apply) begin
          div_next  = new_reg;
          pend_next = 1'b0;
        end

        // A write is only granted when nothing is pending, so it can never
        // collide with apply. A grant on a boundary cycle therefore just
        // loads the holding register and waits for the next safe point.
        if (wr_en[gi]) begin
          new_next  = cfg_div_i;
          pend_next = 1'b1;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg  <= '0;
          clk_reg  <= 1'b0;
          div_reg  <= DIV_W'(DIV_RST);
          new_reg  <= '0;
          pend_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          clk_reg  <= clk_next;
          div_reg  <= div_next;
          new_reg  <= new_next;
          pend_reg <= pend_next;
        end
      end

      assign clk_o[gi]  = clk_reg;
      assign pend_o[gi] = pend_reg;
    end
  endgenerate

endmodule

// File: tb/tb_cluster_clock_divider.sv
module tb_cluster_clock_divider;

  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 4;
  localparam int DIV_RST = 0;
  localparam int CH_W    = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NUM_CH-1:0] en_i = '0;
  logic              cfg_req_i = 1'b0;
  logic [CH_W-1:0]   cfg_ch_i = '0;
  logic [DIV_W-1:0]  cfg_div_i = '0;
  logic              cfg_gnt_o;
  logic [NUM_CH-1:0] pend_o;
  logic [NUM_CH-1:0] clk_o;

  int total = 0;
  int bad = 0;

  cluster_clock_divider #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DIV_RST(DIV_RST)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .cfg_req_i(cfg_req_i),
    .cfg_ch_i(cfg_ch_i),
    .cfg_div_i(cfg_div_i),
    .cfg_gnt_o(cfg_gnt_o),
    .pend_o(pend_o),
    .clk_o(clk_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: each output is described by its level and the number
  // of source edges left before it toggles. A phase lasts div+1 edges.
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_pend;
  int                m_div  [NUM_CH];
  int                m_new  [NUM_CH];
  int                m_left [NUM_CH];

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_clk[c]  = 1'b0;
        m_pend[c] = 1'b0;
        m_div[c]  = DIV_RST;
        m_new[c]  = 0;
        m_left[c] = DIV_RST + 1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic g;
        g = cfg_req_i && (int'(cfg_ch_i) == c) && !m_pend[c];
        if (!m_clk[c] && !en_i[c]) begin
          if (m_pend[c]) begin
            m_div[c]  = m_new[c];
            m_pend[c] = 1'b0;
          end
          m_left[c] = m_div[c] + 1;
        end else begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            if (m_clk[c] && m_pend[c]) begin
              m_div[c]  = m_new[c];
              m_pend[c] = 1'b0;
            end
            m_clk[c]  = !m_clk[c];
            m_left[c] = m_div[c] + 1;
          end
        end
        if (g) begin
          m_new[c]  = int'(cfg_div_i);
          m_pend[c] = 1'b1;
        end
      end
    end
  end

  // Expected {clk_o, pend_o, cfg_gnt_o} for the current inputs.
  function automatic logic [2*NUM_CH:0] expected();
    logic g;
    g = cfg_req_i;
    for (int c = 0; c < NUM_CH; c++)
      if (int'(cfg_ch_i) == c && m_pend[c]) g = 1'b0;
    return {m_clk, m_pend, g};
  endfunction

  task automatic test_reset();
    logic prev;
    rst_i = 1'b1; en_i = '1; cfg_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if ({clk_o, pend_o, cfg_gnt_o} !== '0) begin
      bad++; $display("FAIL reset_state got=%b want=0", {clk_o, pend_o, cfg_gnt_o});
    end
    @(negedge clk_i); rst_i = 1'b0;
    prev = clk_o[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL reset_run got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
      total++;
      if (clk_o[0] === prev) begin
        bad++; $display("FAIL reset_div2 got=%b want=%b", clk_o[0], ~prev);
      end
      prev = clk_o[0];
    end
  endtask

  task automatic test_write_ch0();
    int k;
    int n;
    logic prev1;
    @(negedge clk_i); cfg_req_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 4'd3; #1;
    total++;
    if (cfg_gnt_o !== 1'b1) begin bad++; $display("FAIL write_gnt got=%b want=1", cfg_gnt_o); end
    @(negedge clk_i); cfg_req_i = 1'b0; #1;
    total++;
    if (pend_o[0] !== 1'b1) begin bad++; $display("FAIL write_pend got=%b want=1", pend_o[0]); end
    k = 0;
    while (pend_o[0] === 1'b1 && k < 20) begin
      @(negedge clk_i); #1; k++;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL write_wait got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
    end
    total++;
    if (k >= 20) begin bad++; $display("FAIL write_apply_timeout got=%0d want<20", k); end
    n = 0;
    while (clk_o[0] === 1'b0 && n < 40) begin
      n++; @(negedge clk_i); #1;
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL write_low_len got=%0d want=4", n); end
    n = 0;
    prev1 = clk_o[1];
    while (clk_o[0] === 1'b1 && n < 40) begin
      n++; @(negedge clk_i); #1;
      total++;
      if (clk_o[1] === prev1) begin bad++; $display("FAIL ch1_unaffected got=%b want=%b", clk_o[1], ~prev1); end
      prev1 = clk_o[1];
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL write_high_len got=%0d want=4", n); end
  endtask

  task automatic test_back_to_back();
    int k;
    int len;
    logic started;
    logic prev;
    @(negedge clk_i); cfg_req_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 4'd1; #1;
    total++;
    if (cfg_gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_first_gnt got=%b want=1", cfg_gnt_o); end
    @(negedge clk_i); cfg_div_i = 4'd5; #1;
    total++;
    if (cfg_gnt_o !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want=0", cfg_gnt_o); end
    k = 0;
    while (cfg_gnt_o !== 1'b1 && k < 40) begin
      @(negedge clk_i); #1; k++;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL b2b_wait got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
    end
    total++;
    if (k >= 40) begin bad++; $display("FAIL b2b_gnt_timeout got=%0d want<40", k); end
    @(negedge clk_i); cfg_req_i = 1'b0; #1;
    prev = clk_o[0]; len = 0; started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL b2b_run got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
      len++;
      if (clk_o[0] !== prev) begin
        if (started) begin
          total++;
          if (len < 2) begin bad++; $display("FAIL b2b_min_phase got=%0d want>=2", len); end
        end
        started = 1'b1; len = 0; prev = clk_o[0];
      end
    end
  endtask

  task automatic test_enable();
    int k;
    int n;
    logic prev;
    @(negedge clk_i); cfg_req_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 4'd4;
    @(negedge clk_i); cfg_req_i = 1'b0;
    k = 0;
    while (pend_o[1] === 1'b1 && k < 30) begin @(negedge clk_i); k++; end
    prev = clk_o[1]; k = 0;
    @(negedge clk_i); #1;
    while (!(clk_o[1] === 1'b1 && prev === 1'b0) && k < 30) begin
      prev = clk_o[1]; @(negedge clk_i); #1; k++;
    end
    total++;
    if (k >= 30) begin bad++; $display("FAIL en_rise_timeout got=%0d want<30", k); end
    @(negedge clk_i); en_i[1] = 1'b0; #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL en_drop got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
      if (clk_o[1] === 1'b1) n++;
      else break;
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL en_high_tail got=%0d want=3", n); end
    repeat (8) @(negedge clk_i);
    #1;
    total++;
    if (clk_o[1] !== 1'b0) begin bad++; $display("FAIL en_stopped got=%b want=0", clk_o[1]); end
    @(negedge clk_i); en_i[1] = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1; k++;
      if (clk_o[1] === 1'b1) break;
    end
    total++;
    if (k != 5) begin bad++; $display("FAIL en_restart got=%0d want=5", k); end
  endtask

  task automatic test_out_of_range();
    int k;
    k = 0;
    while (pend_o !== '0 && k < 40) begin @(negedge clk_i); k++; end
    @(negedge clk_i); cfg_req_i = 1'b1; cfg_ch_i = 2'd3; cfg_div_i = 4'd9; #1;
    total++;
    if (cfg_gnt_o !== 1'b1) begin bad++; $display("FAIL oor_gnt got=%b want=1", cfg_gnt_o); end
    @(negedge clk_i); cfg_req_i = 1'b0; #1;
    total++;
    if (pend_o !== '0) begin bad++; $display("FAIL oor_pend got=%b want=000", pend_o); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL oor_run got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
    end
  endtask

  task automatic test_random();
    logic granted;
    logic [2*NUM_CH:0] e;
    int idx;
    granted = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (cfg_req_i && granted) cfg_req_i = 1'b0;
      if (!cfg_req_i && $urandom_range(3) == 0) begin
        cfg_req_i = 1'b1;
        cfg_ch_i  = CH_W'($urandom_range(3));
        cfg_div_i = DIV_W'($urandom_range(15));
      end
      if ($urandom_range(15) == 0) begin
        idx = $urandom_range(NUM_CH - 1);
        en_i[idx] = ~en_i[idx];
      end
      #1;
      e = expected();
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== e) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, {clk_o, pend_o, cfg_gnt_o}, e);
      end
      granted = e[0];
    end
    @(negedge clk_i); cfg_req_i = 1'b0; en_i = '1;
  endtask

  task automatic test_reset_mid();
    int k;
    logic prev;
    @(negedge clk_i); cfg_req_i = 1'b1; cfg_ch_i = 2'd2; cfg_div_i = 4'd7;
    k = 0;
    #1;
    while (cfg_gnt_o !== 1'b1 && k < 80) begin @(negedge clk_i); #1; k++; end
    @(negedge clk_i); cfg_req_i = 1'b0;
    k = 0;
    while (pend_o[2] === 1'b1 && k < 80) begin @(negedge clk_i); k++; end
    prev = clk_o[2]; k = 0;
    @(negedge clk_i); #1;
    while (!(clk_o[2] === 1'b1 && prev === 1'b0) && k < 80) begin
      prev = clk_o[2]; @(negedge clk_i); #1; k++;
    end
    total++;
    if (k >= 80) begin bad++; $display("FAIL rst_rise_timeout got=%0d want<80", k); end
    repeat (2) @(negedge clk_i);
    k = 0;
    while (pend_o[0] === 1'b1 && k < 40) begin @(negedge clk_i); k++; end
    @(negedge clk_i); cfg_req_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 4'd9;
    @(negedge clk_i); cfg_req_i = 1'b0; #1;
    total++;
    if (pend_o[0] !== 1'b1 || clk_o[2] !== 1'b1) begin
      bad++; $display("FAIL rst_pre got=%b%b want=11", pend_o[0], clk_o[2]);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if ({clk_o, pend_o} !== '0) begin bad++; $display("FAIL rst_async got=%b want=0", {clk_o, pend_o}); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    prev = clk_o[2];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({clk_o, pend_o, cfg_gnt_o} !== expected()) begin
        bad++; $display("FAIL rst_after got=%b want=%b", {clk_o, pend_o, cfg_gnt_o}, expected());
      end
      total++;
      if (clk_o[2] === prev) begin bad++; $display("FAIL rst_div2 got=%b want=%b", clk_o[2], ~prev); end
      prev = clk_o[2];
    end
  endtask

  initial begin
    test_reset();
    test_write_ch0();
    test_back_to_back();
    test_enable();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
